// File: rtl/ps2_rx_port.sv
// ps2_rx_port
// Receives PS/2 device frames (start, 8 data bits LSB first, odd parity,
// stop) and queues the received bytes in a small FIFO. The CPU reads the
// FIFO through a shared 16-bit bus.
//
// Parameters
//   FIFO_DEPTH  : byte FIFO entries (power of two, 2..16)
//   TIMEOUT_CYC : clk cycles without a PS/2 falling edge before a partial
//                 frame is abandoned
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   ps2_clk  : PS/2 device clock (asynchronous)
//   ps2_data : PS/2 device data (asynchronous)
//   CS_PS2   : chip select, high for the duration of a CPU read
//   DataBus  : shared bus, driven with {valid, ovf, err, 5'b0, head_byte}
//              while CS_PS2 is high, high-impedance otherwise
//   rx_irq   : registered, high while the FIFO is not empty
//
// Build option
//   PS2_PARITY_CHECK_EN : when defined, frames with wrong (even) parity are
//                         rejected and set err; otherwise parity is ignored.

module ps2_rx_port #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        CS_PS2,
    inout  wire  [15:0] DataBus,
    output logic        rx_irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    logic          ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic          ps2_data_p0, ps2_data_p1;
    logic          fall;
    logic          bit_in;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] tout;
    logic [7:0]    shift_byte;
    logic          parity_bit;
    logic          stop_bit;
    logic          parity_ok;
    logic          frame_ok;
    logic          timeout_evt;
    logic          push_req;
    logic          err_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          not_empty;
    logic          do_push;
    logic          ovf_set;
    logic          ovf, err;

    logic          cs_q;
    logic          cs_block;
    logic          end_acc;
    logic          pop;
    logic [7:0]    head_byte;
    logic [15:0]   live_word;
    logic [15:0]   snap_word;

    // Synchronizer stage: two flops per input, third flop on ps2_clk as history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_clk_p2  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_clk_p2  <= ps2_clk_p1;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    assign fall   = ps2_clk_p2 & ~ps2_clk_p1;
    assign bit_in = ps2_data_p1;

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity: data plus parity bit must hold an odd number of ones
    assign parity_ok = ^{shift_byte, parity_bit};
`else
    logic parity_unused;
    assign parity_unused = parity_bit;
    assign parity_ok     = 1'b1;
`endif

    assign frame_ok    = stop_bit & parity_ok;
    // The counter is reloaded on each edge; running down to 1 with no edge ends the frame
    assign timeout_evt = (state == SHIFT) && !fall && (tout <= TW'(1));
    assign push_req    = (state == CHECK) && frame_ok;
    assign err_set     = ((state == CHECK) && !frame_ok) || timeout_evt;

    // Frame stage: control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            tout    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall && !bit_in) begin
                        bit_cnt <= 4'd0;
                        tout    <= TW'(TIMEOUT_CYC);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        tout    <= TW'(TIMEOUT_CYC);
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) state <= CHECK;
                    end else if (timeout_evt) begin
                        tout  <= '0;
                        state <= IDLE;
                    end else begin
                        tout <= tout - TW'(1);
                    end
                end
                CHECK:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Frame datapath: payload, parity and stop capture
    always_ff @(posedge clk) begin
        if (state == SHIFT && fall) begin
            if (bit_cnt < 4'd8)       shift_byte <= {bit_in, shift_byte[7:1]};
            else if (bit_cnt == 4'd8) parity_bit <= bit_in;
            else                      stop_bit   <= bit_in;
        end
    end

    // Bus access tracking: cs_block suppresses the end of an access that was
    // already in progress when reset released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q     <= 1'b0;
            cs_block <= 1'b1;
        end else begin
            cs_q <= CS_PS2;
            if (!CS_PS2) cs_block <= 1'b0;
        end
    end

    assign end_acc   = cs_q & ~CS_PS2 & ~cs_block;
    // Only pop an entry the CPU actually saw during this access
    assign pop       = end_acc & snap_word[15];
    assign not_empty = (count != '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign do_push   = push_req && (!full || pop);
    assign ovf_set   = push_req && full && !pop;

    // FIFO stage: storage, pointers, count and sticky flags
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            rx_irq <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            ovf    <= ovf_set | (ovf & ~end_acc);
            err    <= err_set | (err & ~end_acc);
            rx_irq <= not_empty;
        end
    end

    assign head_byte = not_empty ? mem[rd_ptr] : 8'h00;
    assign live_word = {not_empty, ovf, err, 5'b00000, head_byte};

    // Read stage: snapshot frozen while CS_PS2 is high so the bus is stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       snap_word <= 16'h0000;
        else if (!CS_PS2) snap_word <= live_word;
    end

    assign DataBus = (CS_PS2 && rst_n) ? snap_word : 16'bz;

endmodule

// File: tb/tb_ps2_rx_port.sv
module tb_ps2_rx_port;

    localparam int DEPTH = 4;
    localparam int TOUT  = 100;
    localparam int H     = 8;   // clk cycles per PS/2 half period

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic        CS_PS2   = 1'b0;
    wire  [15:0] DataBus;
    logic        rx_irq;

    ps2_rx_port #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .CS_PS2   (CS_PS2),
        .DataBus  (DataBus),
        .rx_irq   (rx_irq)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mq[$];
    bit         m_ovf   = 1'b0;
    bit         m_err   = 1'b0;
    bit         stable  = 1'b0;

    function automatic logic [15:0] model_word();
        logic [7:0] h;
        h = (mq.size() != 0) ? mq[0] : 8'h00;
        return {(mq.size() != 0), m_ovf, m_err, 5'b00000, h};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the queue model while nothing is in flight
    always @(negedge clk) begin
        if (stable && rst_n) begin
            check("irq_vs_model", 16'(rx_irq), 16'((mq.size() != 0) ? 1 : 0));
            if (CS_PS2) check("bus_vs_model", DataBus, model_word());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input bit b);
        ps2_data = b;
        tick(H);
        ps2_clk = 1'b0;
        tick(H);
        ps2_clk = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit par_good, input bit stop);
        if (!stop)                      m_err = 1'b1;
        else if (PAR_EN && !par_good)   m_err = 1'b1;
        else if (mq.size() == DEPTH)    m_ovf = 1'b1;
        else                            mq.push_back(d);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_good, input bit stop);
        stable = 1'b0;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par_good ? ~(^d) : (^d));
        ps2_bit(stop);
        ps2_data = 1'b1;
        tick(10);
        model_frame(d, par_good, stop);
        stable = 1'b1;
    endtask

    task automatic send_timeout(input logic [7:0] d, input int nbits);
        stable = 1'b0;
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
        ps2_data = 1'b1;
        tick(TOUT + 20);
        m_err  = 1'b1;
        stable = 1'b1;
    endtask

    task automatic read_bus(output logic [15:0] w);
        CS_PS2 = 1'b1;
        tick(1);
        w = DataBus;
        tick(2);
        CS_PS2 = 1'b0;
        stable = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        m_ovf = 1'b0;
        m_err = 1'b0;
        tick(3);
        stable = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        logic [7:0]  d;
        int          r;

        // Reset state
        rst_n = 1'b0;
        tick(3);
        check("reset_irq", 16'(rx_irq), 16'd0);
        rst_n = 1'b1;
        tick(3);
        stable = 1'b1;
        read_bus(w);
        check("reset_read", w, 16'h0000);

        // Single byte, then empty read
        send_frame(8'hFA, 1'b1, 1'b1);
        check("fa_irq_set", 16'(rx_irq), 16'd1);
        read_bus(w);
        check("fa_read", w, 16'h80FA);
        check("fa_irq_clr", 16'(rx_irq), 16'd0);
        read_bus(w);
        check("fa_empty", w, 16'h0000);

        // Overflow: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
        read_bus(w); check("ovf_r1", w, 16'hC001);
        read_bus(w); check("ovf_r2", w, 16'h8002);
        read_bus(w); check("ovf_r3", w, 16'h8003);
        read_bus(w); check("ovf_r4", w, 16'h8004);
        read_bus(w); check("ovf_r5", w, 16'h0000);

        // Bad stop bit
        send_frame(8'h55, 1'b1, 1'b0);
        read_bus(w); check("stop_err", w, 16'h2000);
        read_bus(w); check("stop_err_clr", w, 16'h0000);

        // Wrong parity
        send_frame(8'h55, 1'b0, 1'b1);
        read_bus(w); check("parity", w, PAR_EN ? 16'h2000 : 16'h8055);
        read_bus(w); check("parity_clr", w, 16'h0000);

        // Timeout after four data bits, then a good frame
        send_timeout(8'hA5, 4);
        send_frame(8'h3C, 1'b1, 1'b1);
        read_bus(w); check("timeout_then_3c", w, 16'hA03C);
        read_bus(w); check("timeout_clr", w, 16'h0000);

        // Reset mid-frame and during an access
        send_frame(8'h99, 1'b1, 1'b1);
        stable = 1'b0;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        CS_PS2 = 1'b1;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("rst_irq", 16'(rx_irq), 16'd0);
        tick(2);
        mq.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
        rst_n = 1'b1;
        tick(2);
        CS_PS2 = 1'b0;
        tick(3);
        stable = 1'b1;
        check("rst_irq_after", 16'(rx_irq), 16'd0);
        read_bus(w); check("rst_empty", w, 16'h0000);
        send_frame(8'h10, 1'b1, 1'b1);
        read_bus(w); check("rst_then_10", w, 16'h8010);

        // Randomized traffic against the queue model
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 99);
            d = 8'($urandom);
            if (r < 40)      send_frame(d, 1'b1, 1'b1);
            else if (r < 48) send_frame(d, 1'b1, 1'b0);
            else if (r < 56) send_frame(d, 1'b0, 1'b1);
            else if (r < 60) send_timeout(d, $urandom_range(0, 7));
            else             read_bus(w);
        end
        for (int i = 0; i < DEPTH + 1; i++) read_bus(w);
        check("drain_empty", w, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
